// File: rtl/datapath_pkg.sv
// Shared types and constants for the datapath sequencer: controller states,
// instruction encodings, register-select and write-back source codes, and
// the bundle of control pins driven towards the datapath.
package datapath_pkg;

  // Controller states. All eight 3-bit codes are assigned.
  typedef enum logic [2:0] {
    WAIT   = 3'd0,
    DECODE = 3'd1,
    WR_IMM = 3'd2,
    GET_A  = 3'd3,
    GET_B  = 3'd4,
    EXEC   = 3'd5,
    CMP_S  = 3'd6,
    WR_REG = 3'd7
  } state_e;

  // Instruction class after decoding the latched {opcode, op}.
  typedef enum logic [2:0] {
    INS_UNDEF   = 3'd0,
    INS_MOV_IMM = 3'd1,
    INS_MOV_REG = 3'd2,
    INS_ADD     = 3'd3,
    INS_CMP     = 3'd4,
    INS_AND     = 3'd5,
    INS_MVN     = 3'd6
  } instr_e;

  // Opcode classes.
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Sub-operations.
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // One-hot register-number selects.
  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b100;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b001;

  // Write-back sources.
  localparam logic [1:0] VSEL_C      = 2'b00;
  localparam logic [1:0] VSEL_SXIMM8 = 2'b10;

  // Control pins driven towards the datapath.
  typedef struct packed {
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       write;
  } ctrl_t;

  // Control value held while idle: only w asserted, nothing else active.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c        = '0;
    c.w      = 1'b1;
    c.nsel   = NSEL_NONE;
    c.vsel   = VSEL_C;
    return c;
  endfunction

  // Map a raw {opcode, op} pair onto an instruction class.
  // MOV sub-ops other than immediate/register are treated as undefined.
  function automatic instr_e classify_instr(input logic [4:0] ir);
    instr_e cls;
    cls = INS_UNDEF;
    case (ir[4:2])
      OPC_MOV: begin
        case (ir[1:0])
          OP_MOV_IMM: cls = INS_MOV_IMM;
          OP_MOV_REG: cls = INS_MOV_REG;
          default:    cls = INS_UNDEF;
        endcase
      end
      OPC_ALU: begin
        case (ir[1:0])
          OP_ADD:  cls = INS_ADD;
          OP_CMP:  cls = INS_CMP;
          OP_AND:  cls = INS_AND;
          OP_MVN:  cls = INS_MVN;
          default: cls = INS_UNDEF;
        endcase
      end
      default: cls = INS_UNDEF;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/datapath_ctrl.sv
// Multi-cycle Moore sequencer for the register-file/ALU datapath. One
// instruction is accepted in WAIT, its {opcode, op} is latched, and the
// controller walks through read, execute and write-back states.
// The control pins come straight from flops; those flops are loaded with the
// decode of the next state so each pin still changes on the same edge as the
// state it belongs to, and an asynchronous reset clears them at once.
module datapath_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write,
  output logic       muxccontrol
);
  import datapath_pkg::*;

  state_e     state_q, state_d;
  logic [4:0] instr_q, instr_d;
  ctrl_t      ctrl_q,  ctrl_d;
  instr_e     ins_q;
  instr_e     ins_d;

  assign ins_q = classify_instr(instr_q);
  assign ins_d = classify_instr(instr_d);

  // Next-state selection and instruction latching on WAIT->DECODE.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    case (state_q)
      WAIT: begin
        if (s) begin
          state_d = DECODE;
          instr_d = {opcode, op};
        end else begin
          state_d = WAIT;
        end
      end
      DECODE: begin
        case (ins_q)
          INS_MOV_IMM:                state_d = WR_IMM;
          INS_MOV_REG, INS_MVN:       state_d = GET_B;
          INS_ADD, INS_AND, INS_CMP:  state_d = GET_A;
          default:                    state_d = WAIT;
        endcase
      end
      GET_A: state_d = GET_B;
      GET_B: begin
        if (ins_q == INS_CMP) begin
          state_d = CMP_S;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC:   state_d = WR_REG;
      CMP_S:  state_d = WAIT;
      WR_IMM: state_d = WAIT;
      WR_REG: state_d = WAIT;
      default: state_d = WAIT;
    endcase
  end

  // Control pin decode for the state being entered on the next edge.
  always_comb begin
    ctrl_d      = '0;
    ctrl_d.nsel = NSEL_NONE;
    ctrl_d.vsel = VSEL_C;
    case (state_d)
      WAIT: begin
        ctrl_d.w = 1'b1;
      end
      DECODE: begin
        ctrl_d.w = 1'b0;
      end
      WR_IMM: begin
        ctrl_d.nsel  = NSEL_RN;
        ctrl_d.vsel  = VSEL_SXIMM8;
        ctrl_d.write = 1'b1;
      end
      GET_A: begin
        ctrl_d.nsel  = NSEL_RN;
        ctrl_d.loada = 1'b1;
      end
      GET_B: begin
        ctrl_d.nsel  = NSEL_RM;
        ctrl_d.loadb = 1'b1;
      end
      EXEC: begin
        // MOV-register and MVN pass B through with A forced to zero.
        ctrl_d.loadc = 1'b1;
        ctrl_d.bsel  = 1'b0;
        if ((ins_d == INS_MOV_REG) || (ins_d == INS_MVN)) begin
          ctrl_d.asel = 1'b1;
        end else begin
          ctrl_d.asel = 1'b0;
        end
        // Status is only updated by the result-producing ALU ops.
        if ((ins_d == INS_ADD) || (ins_d == INS_AND) || (ins_d == INS_MVN)) begin
          ctrl_d.loads = 1'b1;
        end else begin
          ctrl_d.loads = 1'b0;
        end
      end
      CMP_S: begin
        ctrl_d.loads = 1'b1;
      end
      WR_REG: begin
        ctrl_d.nsel  = NSEL_RD;
        ctrl_d.vsel  = VSEL_C;
        ctrl_d.write = 1'b1;
      end
      default: begin
        ctrl_d = ctrl_idle();
      end
    endcase
  end

  // State, latched instruction and control-pin registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT;
      instr_q <= 5'b00000;
      ctrl_q  <= ctrl_idle();
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign w           = ctrl_q.w;
  assign nsel        = ctrl_q.nsel;
  assign vsel        = ctrl_q.vsel;
  assign loada       = ctrl_q.loada;
  assign loadb       = ctrl_q.loadb;
  assign loadc       = ctrl_q.loadc;
  assign loads       = ctrl_q.loads;
  assign asel        = ctrl_q.asel;
  assign bsel        = ctrl_q.bsel;
  assign write       = ctrl_q.write;
  // A and B always load from the register-file read port.
  assign muxccontrol = 1'b0;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Self-checking bench for datapath_ctrl. A reference model expands each
// instruction into the list of per-cycle control vectors the controller must
// produce, and every cycle is compared on the falling clock edge.
module tb_datapath_ctrl;

  logic       clk;
  logic       reset;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       loada, loadb, loadc, loads, asel, bsel, write, muxccontrol;

  int n_vec;
  int n_err;

  // Expected per-cycle vectors after the start edge, ending with WAIT.
  logic [13:0] exp_q[$];

  datapath_ctrl dut (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
    .w(w), .nsel(nsel), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .write(write), .muxccontrol(muxccontrol)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  // Pack {muxccontrol, w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write}.
  function automatic logic [13:0] pk(input logic ww, input logic [2:0] n, input logic [1:0] v,
                                     input logic la, input logic lb, input logic lc,
                                     input logic ls, input logic as, input logic bs,
                                     input logic wr);
    return {1'b0, ww, n, v, la, lb, lc, ls, as, bs, wr};
  endfunction

  function automatic logic [13:0] observed();
    return {muxccontrol, w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write};
  endfunction

  // Reference model: control vectors each cycle for one instruction.
  function automatic void build_exp(input logic [2:0] opc, input logic [1:0] o);
    logic [13:0] v_wait, v_dec, v_wr_imm, v_get_a, v_get_b, v_wr_reg;
    v_wait   = pk(1'b1, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    v_dec    = pk(1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    v_wr_imm = pk(1'b0, 3'b100, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    v_get_a  = pk(1'b0, 3'b100, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    v_get_b  = pk(1'b0, 3'b001, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    v_wr_reg = pk(1'b0, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.delete();
    exp_q.push_back(v_dec);
    if (opc == 3'b110 && o == 2'b10) begin
      exp_q.push_back(v_wr_imm);
    end else if (opc == 3'b110 && o == 2'b00) begin
      exp_q.push_back(v_get_b);
      exp_q.push_back(pk(1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(v_wr_reg);
    end else if (opc == 3'b101 && o == 2'b11) begin
      exp_q.push_back(v_get_b);
      exp_q.push_back(pk(1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(v_wr_reg);
    end else if (opc == 3'b101 && o == 2'b01) begin
      exp_q.push_back(v_get_a);
      exp_q.push_back(v_get_b);
      exp_q.push_back(pk(1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    end else if (opc == 3'b101) begin
      exp_q.push_back(v_get_a);
      exp_q.push_back(v_get_b);
      exp_q.push_back(pk(1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(v_wr_reg);
    end
    exp_q.push_back(v_wait);
  endfunction

  // Start one instruction from WAIT (called at a falling edge) and compare
  // every cycle up to and including the return to WAIT.
  task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input bit hold,
                           input bit mutate, input string name);
    logic [13:0] got;
    opcode = opc;
    op     = o;
    s      = 1'b1;
    build_exp(opc, o);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        if (!hold) s = 1'b0;
        if (mutate) begin
          opcode = 3'($urandom);
          op     = 2'($urandom);
        end
      end
      @(negedge clk);
      got = observed();
      n_vec++;
      if (got !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s cycle %0d: got %b, expected %b", name, i + 1, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    logic [13:0] idle_v;
    idle_v = pk(1'b1, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    s = 1'b0;
    @(negedge clk);
    n_vec++;
    if (observed() !== idle_v) begin
      n_err++;
      $display("FAIL reset_value: got %b, expected %b", observed(), idle_v);
    end
    reset = 1'b0;
    @(negedge clk);
    // ADD up to GET_B, then reset asynchronously mid-cycle.
    opcode = 3'b101; op = 2'b00; s = 1'b1;
    @(posedge clk); #1 s = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (observed() !== pk(1'b0, 3'b001, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      n_err++;
      $display("FAIL reset_pre_get_b: got %b, expected loadb with nsel 001", observed());
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (observed() !== idle_v) begin
      n_err++;
      $display("FAIL reset_async: got %b, expected %b", observed(), idle_v);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (observed() !== idle_v) begin
        n_err++;
        $display("FAIL reset_stay_wait cycle %0d: got %b, expected %b", i, observed(), idle_v);
      end
    end
  endtask

  task automatic test_mov_imm();
    run_instr(3'b110, 2'b10, 1'b0, 1'b0, "mov_imm");
  endtask

  task automatic test_add();
    run_instr(3'b101, 2'b00, 1'b0, 1'b0, "add");
    run_instr(3'b101, 2'b10, 1'b0, 1'b0, "and");
  endtask

  task automatic test_cmp();
    run_instr(3'b101, 2'b01, 1'b0, 1'b0, "cmp");
  endtask

  task automatic test_mov_reg_mvn();
    run_instr(3'b110, 2'b00, 1'b0, 1'b0, "mov_reg");
    run_instr(3'b101, 2'b11, 1'b0, 1'b0, "mvn");
    run_instr(3'b110, 2'b00, 1'b0, 1'b1, "mov_reg_mutate");
    run_instr(3'b101, 2'b11, 1'b0, 1'b1, "mvn_mutate");
  endtask

  task automatic test_back_to_back();
    run_instr(3'b000, 2'($urandom), 1'b1, 1'b0, "undef_hold");
    run_instr(3'b110, 2'b10, 1'b1, 1'b0, "b2b_mov_imm");
    run_instr(3'b101, 2'b00, 1'b0, 1'b0, "b2b_add");
  endtask

  task automatic test_random();
    logic [2:0] opc;
    logic [1:0] o;
    int         pick;
    bit         hold;
    for (int k = 0; k < 60; k++) begin
      pick = $urandom_range(0, 6);
      case (pick)
        0: begin opc = 3'b110; o = 2'b10; end
        1: begin opc = 3'b110; o = 2'b00; end
        2, 3, 4, 5: begin opc = 3'b101; o = 2'(pick - 2); end
        default: begin
          opc = 3'($urandom);
          while (opc == 3'b110 || opc == 3'b101) opc = 3'($urandom);
          o = 2'($urandom);
        end
      endcase
      hold = (k == 59) ? 1'b0 : 1'($urandom);
      run_instr(opc, o, hold, 1'($urandom), "random");
    end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    reset  = 1'b1;
    s      = 1'b0;
    opcode = 3'b000;
    op     = 2'b00;
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_mov_reg_mvn();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
